// File: rtl/def_params.sv
// Shared definitions for the memory arbiter: bus widths, default abort limit
// and the arbiter state encodings.
package def_params;

    localparam int ADDR_SIZE              = 31;
    localparam int INSTR_SIZE             = 31;
    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT_I = 2'd1;
    localparam logic [1:0] ARB_GRANT_D = 2'd2;

endpackage

// File: rtl/mem_arb_timer.sv
// Grant-cycle counter: counts cycles spent in a grant state and flags when the
// abort limit is reached. Saturates at the limit instead of wrapping.
`default_nettype none

module mem_arb_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_LIMIT)) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign expired = (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single memory bus, one transaction in
// flight, with grant timeout. MEM_ARB_RR_EN enables round-robin contention.
`default_nettype none

module mem_arbiter
    import def_params::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_SIZE:0]  i_addr,
    output logic [INSTR_SIZE:0] i_rdata,
    output logic                i_ready,
    input  logic                d_r_enable,
    input  logic                d_w_enable,
    input  logic [ADDR_SIZE:0]  d_addr,
    input  logic [1:0]          d_w_size,
    input  logic [INSTR_SIZE:0] d_w_data,
    output logic [INSTR_SIZE:0] d_r_data,
    output logic                d_ready,
    output logic [ADDR_SIZE:0]  mem_addr,
    output logic                mem_r_enable,
    output logic                mem_w_enable,
    output logic [1:0]          mem_w_size,
    output logic [INSTR_SIZE:0] mem_w_data,
    input  logic [INSTR_SIZE:0] mem_r_data,
    input  logic                mem_ready,
    output logic                busy,
    output logic                timeout_err
);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_d_req;
    logic       w_pick_d;
    logic       w_expired;
    logic       w_start;
    logic       w_done;
    logic       w_abort;

    assign w_d_req = d_r_enable | d_w_enable;

`ifdef MEM_ARB_RR_EN
    // Remembers the last granted port; reset value means "fetch went last".
    logic r_last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (w_start) begin
            r_last_d <= (w_next_state == ARB_GRANT_D);
        end
    end

    assign w_pick_d = ~r_last_d;
`else
    assign w_pick_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_d_req && i_req) begin
                    w_next_state = w_pick_d ? ARB_GRANT_D : ARB_GRANT_I;
                end else if (w_d_req) begin
                    w_next_state = ARB_GRANT_D;
                end else if (i_req) begin
                    w_next_state = ARB_GRANT_I;
                end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
                if (mem_ready || w_expired) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != ARB_IDLE);
        w_start = (r_state == ARB_IDLE) && (w_next_state != ARB_IDLE);
        w_done  = busy && (mem_ready || w_expired);
        // A response arriving on the limit cycle still counts as a completion.
        w_abort = busy && w_expired && !mem_ready;
    end

    mem_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_next_state == ARB_IDLE),
        .en      (w_next_state != ARB_IDLE),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr     <= '0;
            mem_r_enable <= 1'b0;
            mem_w_enable <= 1'b0;
            mem_w_size   <= '0;
            mem_w_data   <= '0;
            i_rdata      <= '0;
            i_ready      <= 1'b0;
            d_r_data     <= '0;
            d_ready      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (w_start) begin
                if (w_next_state == ARB_GRANT_D) begin
                    mem_addr     <= d_addr;
                    mem_r_enable <= d_r_enable & ~d_w_enable;
                    mem_w_enable <= d_w_enable;
                    mem_w_size   <= d_w_enable ? d_w_size : 2'b00;
                    mem_w_data   <= d_w_enable ? d_w_data : '0;
                end else begin
                    mem_addr     <= i_addr;
                    mem_r_enable <= 1'b1;
                    mem_w_enable <= 1'b0;
                    mem_w_size   <= 2'b00;
                    mem_w_data   <= '0;
                end
            end else if (w_done) begin
                mem_addr     <= '0;
                mem_r_enable <= 1'b0;
                mem_w_enable <= 1'b0;
                mem_w_size   <= 2'b00;
                mem_w_data   <= '0;
                if (r_state == ARB_GRANT_I) begin
                    i_ready <= 1'b1;
                    i_rdata <= w_abort ? '0 : mem_r_data;
                end else begin
                    // mem_w_enable still holds the latched write flag here.
                    d_ready  <= 1'b1;
                    d_r_data <= (w_abort || mem_w_enable) ? '0 : mem_r_data;
                end
                if (w_abort) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
